sensor_qualifier: RTL and testbench

Front-end stage that feeds the grading FSM. It takes three raw, possibly bouncing sensor/switch levels (weight, size, colour) plus an asynchronous measure trigger. It synchronises and debounces each level. On each trigger it waits for all channels to settle, then captures one coherent frame. The frame drives the FSM's weight_ok/size_ok/color_ok inputs and is held stable between measurements.

---
 rtl/sensor_qualifier.sv | 145 ++++++++++++++
 tb/tb_sensor_qualifier.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sensor_qualifier.sv
// Front end for the grading FSM: synchronises and debounces three sensor levels
// and, on each measure trigger, captures one settled frame that is held until the next.
module sensor_qualifier #(
  parameter int DEB_CYCLES     = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic weight_raw_i,
  input  logic size_raw_i,
  input  logic color_raw_i,
  input  logic sample_i,
  output logic weight_ok_o,
  output logic size_ok_o,
  output logic color_ok_o,
  output logic valid_o,
  output logic busy_o,
  output logic timeout_o
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  // bit order {sample, color, size, weight}
  logic [3:0] meta_q, sync_q;
  logic       sample_prev_q, trig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q        <= '0;
      sync_q        <= '0;
      sample_prev_q <= 1'b0;
      trig_q        <= 1'b0;
    end else begin
      meta_q        <= {sample_i, color_raw_i, size_raw_i, weight_raw_i};
      sync_q        <= meta_q;
      sample_prev_q <= sync_q[3];
      // registered so SETTLE begins a fixed three edges after sample_i is first sampled
      trig_q        <= sync_q[3] & ~sample_prev_q;
    end
  end

  logic [2:0]         deb_q, deb_d;
  logic [2:0][DW-1:0] dcnt_q, dcnt_d;
  logic               all_quiet;

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync_q[i] == deb_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DW'(DEB_CYCLES - 1)) begin
        deb_d[i]  = sync_q[i];
        dcnt_d[i] = '0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
  end

  assign all_quiet = (dcnt_q[0] == '0) && (dcnt_q[1] == '0) && (dcnt_q[2] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q  <= '0;
      dcnt_q <= '0;
    end else begin
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
    end
  end

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [2:0]    ok_q, ok_d;
  logic          tmo_q, tmo_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tout_d   = tout_q;
    ok_d     = ok_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (trig_q) begin
          state_d  = SETTLE;
          settle_d = '0;
          tout_d   = '0;
        end
      end
      SETTLE: begin
        tout_d   = tout_q + 1'b1;
        settle_d = all_quiet ? settle_q + 1'b1 : '0;
        // a settled frame takes priority over an expiring timeout
        if (settle_q == SW'(SETTLE_CYCLES)) begin
          state_d = CAPTURE;
          ok_d    = deb_q;
          tmo_d   = 1'b0;
        end else if (tout_q == TW'(TIMEOUT_CYCLES)) begin
          state_d = CAPTURE;
          ok_d    = deb_q;
          tmo_d   = 1'b1;
        end
      end
      CAPTURE: state_d = HOLD;
      default: begin
        if (!sync_q[3]) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      tout_q   <= '0;
      ok_q     <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      tout_q   <= tout_d;
      ok_q     <= ok_d;
      tmo_q    <= tmo_d;
    end
  end

  assign weight_ok_o = ok_q[0];
  assign size_ok_o   = ok_q[1];
  assign color_ok_o  = ok_q[2];
  assign valid_o     = (state_q == CAPTURE);
  assign busy_o      = (state_q != IDLE);
  assign timeout_o   = tmo_q;

endmodule

// File: tb/tb_sensor_qualifier.sv
// Directed bench for sensor_qualifier: capture latency, debounce, trigger
// filtering, forced capture, reset abort and output hold.
module tb_sensor_qualifier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic w = 1'b0, s = 1'b0, c = 1'b0, smp = 1'b0;
  logic weight_ok, size_ok, color_ok, valid, busy, tmo;

  sensor_qualifier dut (
    .clk(clk), .rst(rst),
    .weight_raw_i(w), .size_raw_i(s), .color_raw_i(c), .sample_i(smp),
    .weight_ok_o(weight_ok), .size_ok_o(size_ok), .color_ok_o(color_ok),
    .valid_o(valid), .busy_o(busy), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcnt = 0;
  int vcyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) begin
      vcnt = vcnt + 1;
      vcyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int lim, output logic got);
    got = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_frame(input string tag, input logic [2:0] exp_wsc, input logic exp_tmo);
    chk({tag, "_w"}, 32'(weight_ok), 32'(exp_wsc[2]));
    chk({tag, "_s"}, 32'(size_ok), 32'(exp_wsc[1]));
    chk({tag, "_c"}, 32'(color_ok), 32'(exp_wsc[0]));
    chk({tag, "_tmo"}, 32'(tmo), 32'(exp_tmo));
  endtask

  initial begin
    int t0;
    int v0;
    logic got;
    logic bad;

    // reset state
    w = 1'b1; s = 1'b0; c = 1'b1; smp = 1'b0;
    tick(3);
    chk_frame("rst", 3'b000, 1'b0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(20);

    // 1: basic latency, busy window and captured frame
    v0 = vcnt; t0 = cyc; smp = 1'b1;
    tick(3);
    chk("t1_busy_e2", 32'(busy), 32'd0);
    smp = 1'b0;
    tick(1);
    chk("t1_busy_e3", 32'(busy), 32'd1);
    tick(10);
    chk("t1_busy_e13", 32'(busy), 32'd1);
    chk("t1_vcnt", 32'(vcnt - v0), 32'd1);
    chk("t1_latency", 32'(vcyc - t0), 32'd13);
    chk_frame("t1", 3'b101, 1'b0);
    tick(1);
    chk("t1_busy_e14", 32'(busy), 32'd0);

    // 2a: 3-cycle glitch on size is rejected
    tick(5);
    s = 1'b1; tick(3); s = 1'b0; tick(2);
    smp = 1'b1; tick(3); smp = 1'b0;
    wait_valid(40, got);
    chk("t2a_got", 32'(got), 32'd1);
    chk("t2a_size", 32'(size_ok), 32'd0);

    // 2b: 4-cycle pulse is accepted then released; settling waits for it, capture sees 0
    tick(10);
    s = 1'b1; tick(4);
    s = 1'b0; t0 = cyc; smp = 1'b1; tick(3); smp = 1'b0;
    wait_valid(40, got);
    chk("t2b_got", 32'(got), 32'd1);
    chk("t2b_size", 32'(size_ok), 32'd0);
    chk("t2b_latency", 32'(vcyc - t0), 32'd15);

    // 2c: steady size high is captured
    tick(5);
    s = 1'b1; tick(10);
    smp = 1'b1; tick(3); smp = 1'b0;
    wait_valid(40, got);
    chk("t2c_got", 32'(got), 32'd1);
    chk("t2c_size", 32'(size_ok), 32'd1);
    s = 1'b0;

    // 3: held trigger plus an extra edge during SETTLE gives one frame
    tick(10);
    v0 = vcnt;
    smp = 1'b1; tick(5); smp = 1'b0; tick(1); smp = 1'b1; tick(50);
    chk("t3_hold_busy", 32'(busy), 32'd1);
    chk("t3_one_valid", 32'(vcnt - v0), 32'd1);
    chk("t3_size", 32'(size_ok), 32'd0);
    smp = 1'b0; tick(5);
    chk("t3_idle", 32'(busy), 32'd0);
    smp = 1'b1; tick(3); smp = 1'b0;
    wait_valid(40, got);
    chk("t3_got2", 32'(got), 32'd1);
    tick(2);
    chk("t3_two_valid", 32'(vcnt - v0), 32'd2);

    // 4: colour chatter keeps SETTLE from settling -> forced capture
    tick(5);
    v0 = vcnt; t0 = cyc;
    for (int i = 0; i < 80; i++) begin
      c = ((i / 2) % 2) == 1;
      smp = (i < 3);
      tick(1);
    end
    c = 1'b1;
    chk("t4_one_valid", 32'(vcnt - v0), 32'd1);
    chk("t4_latency", 32'(vcyc - t0), 32'd69);
    chk_frame("t4", 3'b101, 1'b1);
    tick(10);
    smp = 1'b1; tick(3); smp = 1'b0;
    wait_valid(40, got);
    chk("t4_clean_got", 32'(got), 32'd1);
    chk_frame("t4_clean", 3'b101, 1'b0);

    // 5: reset five cycles into SETTLE aborts the measurement
    tick(5);
    smp = 1'b1; tick(3); smp = 1'b0; tick(6);
    chk("t5_in_settle", 32'(busy), 32'd1);
    v0 = vcnt;
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(valid), 32'd0);
    chk_frame("t5_rst", 3'b000, 1'b0);
    tick(30);
    chk("t5_no_valid", 32'(vcnt - v0), 32'd0);
    smp = 1'b1; tick(3); smp = 1'b0;
    wait_valid(40, got);
    chk("t5_got", 32'(got), 32'd1);
    chk_frame("t5_after", 3'b101, 1'b0);

    // 6: raw changes without a trigger never reach the outputs
    tick(5);
    v0 = vcnt; bad = 1'b0;
    w = 1'b0; s = 1'b1; c = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if ({weight_ok, size_ok, color_ok} !== 3'b101) bad = 1'b1;
    end
    chk("t6_stable", 32'(bad), 32'd0);
    chk("t6_no_valid", 32'(vcnt - v0), 32'd0);
    chk_frame("t6", 3'b101, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
